// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider: FSM states,
// counter sizing and the quotient returned on a zero divisor.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // All ones; sliced to WIDTH by the user.
    localparam logic [31:0] DBZ_QUOTIENT = '1;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {A,Q} left, ripple-subtract D from A
// at WIDTH+1 bits, keep the difference or restore based on the borrow.
module div_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] sa;
    logic [WIDTH:0] sub;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] borrow;
    logic           keep;

    always_comb begin
        sa     = {a[WIDTH-1:0], q[WIDTH-1]};
        sub    = {1'b0, d};
        borrow = '0;
        diff   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            borrow[i+1] = (~sa[i] & sub[i]) | (~(sa[i] ^ sub[i]) & borrow[i]);
        end
        for (int unsigned i = 0; i <= WIDTH; i++) begin
            diff[i] = sa[i] ^ sub[i] ^ borrow[i];
        end
        // A set top bit of A would make the shifted value exceed any divisor.
        keep = ~diff[WIDTH] | a[WIDTH];
        if (keep) begin
            a_next = diff;
            q_next = {q[WIDTH-2:0], 1'b1};
        end else begin
            a_next = sa;
            q_next = {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned divider: one quotient bit per clock through div_step,
// start/done handshake, registered results held until the next completion.
module restoring_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   a_next;
    logic [WIDTH-1:0] q_next;
    logic             accept;
    logic             last_step;

    div_step #(.WIDTH(WIDTH)) u_step (
        .a      (a),
        .q      (q),
        .d      (d),
        .a_next (a_next),
        .q_next (q_next)
    );

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = start && (state != CALC);
        last_step  = (cnt == CW'(1));
        case (state)
            IDLE: begin
                if (accept) state_next = (divisor == '0) ? DONE : CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last_step) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (accept) state_next = (divisor == '0) ? DONE : CALC;
                else        state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            a   <= '0;
            q   <= dividend;
            d   <= divisor;
            cnt <= CW'(WIDTH);
            if (divisor == '0) begin
                quotient    <= DBZ_QUOTIENT[WIDTH-1:0];
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == CALC) begin
            a   <= a_next;
            q   <= q_next;
            cnt <= cnt - CW'(1);
            if (last_step) begin
                quotient    <= q_next;
                remainder   <= a_next[WIDTH-1:0];
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider (WIDTH=8): vector table,
// handshake corner sequences and random operands against an arithmetic model.
module tb_restoring_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int total = 0;
    int bad = 0;

    restoring_divider #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] n;
        logic [7:0] d;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        int         lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Drive one start pulse; returns at the first negedge after the accepting edge.
    task automatic issue(input logic [7:0] n, input logic [7:0] dv);
        @(negedge clk);
        start = 1'b1;
        dividend = n;
        divisor = dv;
        @(negedge clk);
        start = 1'b0;
        dividend = 8'($urandom);
        divisor = 8'($urandom);
    endtask

    // Sample from the current negedge until done, bounded.
    task automatic wait_done(output int lat, output int bcnt);
        lat = 1;
        bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (!done) check("timeout", 32'(done), 32'd1);
    endtask

    task automatic model(input logic [7:0] n, input logic [7:0] dv,
                         output logic [7:0] q, output logic [7:0] r, output logic z);
        if (dv == 0) begin
            q = 8'hFF; r = n; z = 1'b1;
        end else begin
            q = n / dv; r = n % dv; z = 1'b0;
        end
    endtask

    initial begin
        int lat, bcnt, dcount;
        logic [7:0] eq, er, prev_q;
        logic ez;

        vecs[0] = '{n: 100, d: 7,   q: 14,  r: 2,  z: 0, lat: 9};
        vecs[1] = '{n: 255, d: 1,   q: 255, r: 0,  z: 0, lat: 9};
        vecs[2] = '{n: 5,   d: 9,   q: 0,   r: 5,  z: 0, lat: 9};
        vecs[3] = '{n: 255, d: 255, q: 1,   r: 0,  z: 0, lat: 9};
        vecs[4] = '{n: 42,  d: 0,   q: 255, r: 42, z: 1, lat: 1};
        vecs[5] = '{n: 0,   d: 5,   q: 0,   r: 0,  z: 0, lat: 9};
        vecs[6] = '{n: 200, d: 3,   q: 66,  r: 2,  z: 0, lat: 9};
        vecs[7] = '{n: 128, d: 2,   q: 64,  r: 0,  z: 0, lat: 9};

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_q", 32'(quotient), 0);
        check("rst_r", 32'(remainder), 0);
        check("rst_z", 32'(div_by_zero), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].n, vecs[i].d);
            wait_done(lat, bcnt);
            check("vec_q", 32'(quotient), 32'(vecs[i].q));
            check("vec_r", 32'(remainder), 32'(vecs[i].r));
            check("vec_z", 32'(div_by_zero), 32'(vecs[i].z));
            check("vec_lat", 32'(lat), 32'(vecs[i].lat));
            check("vec_busy_cycles", 32'(bcnt), vecs[i].z ? 32'd0 : 32'd8);
            @(negedge clk);
            check("done_pulse_end", 32'(done), 0);
        end

        // start during CALC is dropped; outputs hold during CALC
        prev_q = quotient;
        issue(100, 7);
        repeat (2) @(negedge clk);
        start = 1'b1; dividend = 50; divisor = 5;
        @(negedge clk);
        start = 1'b0;
        check("hold_q_calc", 32'(quotient), 32'(prev_q));
        wait_done(lat, bcnt);
        check("ign_q", 32'(quotient), 14);
        check("ign_r", 32'(remainder), 2);
        check("ign_lat", 32'(lat), 6);
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("ign_extra_done", 32'(dcount), 0);

        // back-to-back issue in the done cycle
        issue(100, 7);
        wait_done(lat, bcnt);
        check("b2b_q1", 32'(quotient), 14);
        check("b2b_r1", 32'(remainder), 2);
        start = 1'b1; dividend = 200; divisor = 3;
        @(negedge clk);
        start = 1'b0;
        check("b2b_no_idle", 32'(busy), 1);
        wait_done(lat, bcnt);
        check("b2b_q2", 32'(quotient), 66);
        check("b2b_r2", 32'(remainder), 2);
        check("b2b_lat", 32'(lat), 9);

        // reset in CALC cycle 4
        issue(100, 7);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_q", 32'(quotient), 0);
        check("mid_rst_r", 32'(remainder), 0);
        check("mid_rst_z", 32'(div_by_zero), 0);
        @(negedge clk);
        check("mid_rst_no_done", 32'(done), 0);
        rst_n = 1'b1;
        issue(81, 9);
        wait_done(lat, bcnt);
        check("post_rst_q", 32'(quotient), 9);
        check("post_rst_r", 32'(remainder), 0);
        check("post_rst_lat", 32'(lat), 9);

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] n, dv;
            n = 8'($urandom);
            dv = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            model(n, dv, eq, er, ez);
            issue(n, dv);
            wait_done(lat, bcnt);
            check("rnd_q", 32'(quotient), 32'(eq));
            check("rnd_r", 32'(remainder), 32'(er));
            check("rnd_z", 32'(div_by_zero), 32'(ez));
            if (dv != 0) begin
                check("rnd_identity", 32'(quotient) * 32'(dv) + 32'(remainder), 32'(n));
                check("rnd_r_lt_d", 32'(remainder < dv), 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
Multi-cycle unsigned integer divider that computes quotient and remainder by repeated shift-and-subtract, one quotient bit per clock.
- It is the inverse of the ripple full-adder datapath: each step is a WIDTH+1-bit ripple subtract with borrow-based restore.
- Used by the execute stage for DIV/REM instructions through a start/done handshake.

Parameters:
- WIDTH, 8, operand, quotient and remainder width in bits (legal values 2..32).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled on a rising edge only when busy=0.
- dividend  input  WIDTH  unsigned dividend; sampled with an accepted start.
- divisor  input  WIDTH  unsigned divisor; sampled with an accepted start.
- busy  output  1  high while a division is in progress (CALC state).
- done  output  1  one-cycle pulse; results are valid from this cycle.
- quotient  output  WIDTH  registered quotient.
- remainder  output  WIDTH  registered remainder.
- div_by_zero  output  1  registered flag for the last completed operation.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal working registers and counter cleared.
- States:
  - IDLE: busy=0, done=0.
  - CALC: busy=1.
  - DONE: busy=0, done=1 for exactly one cycle.
- Start acceptance: start=1 on an edge while state is IDLE or DONE.
  - Latch dividend into the working quotient register (Q), divisor into D, clear the partial remainder (A, WIDTH+1 bits), load step counter=WIDTH.
  - divisor==0: go directly to DONE. quotient=all ones, remainder=dividend, div_by_zero=1. done is visible one cycle after the start edge.
  - Otherwise: go to CALC.
- start while in CALC: ignored with no side effects. Operands on the ports may change freely after the start edge.
- CALC step (one per edge):
  - {A,Q} shifted left by 1.
  - T = A - {1'b0,D}, computed at WIDTH+1 bits.
  - If T's MSB (borrow) is 0: A=T and Q LSB=1. Else: A unchanged and Q LSB=0.
  - Counter decrements.
  - On the edge that performs the step with counter==1: output registers load quotient=Q_next and remainder=A_next[WIDTH-1:0], div_by_zero=0, and the state goes to DONE.
- Latency: done is high in the cycle following the WIDTH-th edge after the accepting edge (8 cycles for WIDTH=8). Throughput is one operation per WIDTH+1 cycles.
- DONE: the next edge goes to IDLE, or back to CALC/DONE if start=1 (back-to-back issue allowed).
- Outputs quotient/remainder/div_by_zero hold their values until the next completion updates them. They do not change during CALC.
- Reset mid-CALC: abort immediately. No done pulse; outputs return to 0.
- Arithmetic invariants: quotient*divisor + remainder == dividend; remainder < divisor when divisor != 0. Widths never truncate the partial remainder (A is WIDTH+1 bits).

Decomposition:
- Shared package (div_pkg): state enum typedef {IDLE, CALC, DONE}, a counter-width constant $clog2(WIDTH+1), and the div-by-zero quotient constant (all ones).
- One combinational sub-module, div_step: inputs A, Q, D; outputs A_next, Q_next. It contains the shift, the WIDTH+1-bit ripple subtract and the restore mux.
- The top level contains the FSM, counter and output registers.

Test Plan:
1. WIDTH=8, start with dividend=100, divisor=7. Required: busy=1 for 8 cycles, then done pulse, quotient=14, remainder=2, div_by_zero=0.
2. Edge cases:
   - 255/1 gives quotient=255, remainder=0.
   - 5/9 gives quotient=0, remainder=5.
   - 255/255 gives quotient=1, remainder=0.
3. Divide by zero: dividend=42, divisor=0. Required: done one cycle after start, busy never high, quotient=0xFF, remainder=42, div_by_zero=1.
4. Start ignored while busy: start 100/7, then assert start with 50/5 during cycle 3 of CALC. Required: single done with 14 r 2; the second request is dropped.
5. Back-to-back: assert start with 200/3 in the done cycle of 100/7. Required: first result 14 r 2, then 8 cycles later done with 66 r 2; no idle cycle between.
6. Reset mid-operation: rst_n low during CALC cycle 4. Required: busy, done and outputs go to 0 immediately; after release, 81/9 gives 9 r 0 normally. Also run 1000 random operand pairs checking q*d+r==n and r<d.
